// File: rtl/eyeriss_pkg.sv
// Shared constants, types and dimension helpers for the eyeriss psum drain path.
package eyeriss_pkg;

  localparam int G_ARRAY_HEIGHT     = 5;
  localparam int G_ARRAY_WIDTH      = 6;
  localparam int G_TOP_BITS         = 2;
  localparam int G_BOT_BITS         = 14;
  localparam int G_KERNEL_SIZE      = 5;
  localparam int G_IMAGE_HEIGHT     = 28;
  localparam int G_IMAGE_WIDTH      = 28;
  localparam int G_OFMAP_ADDR_WIDTH = 10;

  localparam int DATA_WIDTH = G_TOP_BITS + G_BOT_BITS;

  typedef logic [DATA_WIDTH-1:0] psum_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} collector_state_e;

  function automatic int out_dim(input int image, input int kernel);
    return image - kernel + 1;
  endfunction

  function automatic int row_stride(input int height, input int width, input int kernel);
    return height + width - kernel;
  endfunction

  localparam int OUT_HEIGHT = out_dim(G_IMAGE_HEIGHT, G_KERNEL_SIZE);
  localparam int OUT_WIDTH  = out_dim(G_IMAGE_WIDTH, G_KERNEL_SIZE);
  localparam int ROW_STRIDE = row_stride(G_ARRAY_HEIGHT, G_ARRAY_WIDTH, G_KERNEL_SIZE);

endpackage

// File: rtl/psum_collector_if.sv
// Bundle of per-column show-ahead FIFO signals and the ofmap buffer write port.
interface psum_collector_if #(
  parameter int W  = eyeriss_pkg::G_ARRAY_WIDTH,
  parameter int AW = eyeriss_pkg::G_OFMAP_ADDR_WIDTH
);
  import eyeriss_pkg::*;

  logic [0:W-1]  psum_empty_i;
  psum_t [0:W-1] psum_i;
  logic [0:W-1]  psum_rd_en_o;
  logic          ofmap_wr_en_o;
  logic [AW-1:0] ofmap_wr_addr_o;
  logic [31:0]   ofmap_wr_data_o;

  modport slave (
    input  psum_empty_i, psum_i,
    output psum_rd_en_o, ofmap_wr_en_o, ofmap_wr_addr_o, ofmap_wr_data_o
  );

  modport master (
    output psum_empty_i, psum_i,
    input  psum_rd_en_o, ofmap_wr_en_o, ofmap_wr_addr_o, ofmap_wr_data_o
  );
endinterface

// File: rtl/psum_collector_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last winner.
module psum_rr_arbiter
  import eyeriss_pkg::*;
#(
  parameter int N = G_ARRAY_WIDTH
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         advance_i,
  input  logic [0:N-1] req_i,
  output logic [0:N-1] gnt_o
);
  localparam int PW = $clog2(N);

  logic [PW-1:0] r_last;
  logic [PW-1:0] w_win;

  always_comb begin : grant_search
    logic found;
    int   idx;
    found = 1'b0;
    idx   = 0;
    gnt_o = '0;
    w_win = r_last;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(r_last) + i) % N;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        w_win      = PW'(idx);
      end
    end
  end

  // Parking the pointer on N-1 gives column 0 first priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last <= PW'(N - 1);
    end else if (clear_i) begin
      r_last <= PW'(N - 1);
    end else if (advance_i) begin
      r_last <= w_win;
    end
  end
endmodule

// File: rtl/psum_collector.sv
// Drains the per-column psum FIFOs into a linear ofmap buffer (row*OUT_WIDTH+col).
// Optional macro PSUM_COLLECTOR_RELU_EN clamps negative written values to zero.
module psum_collector
  import eyeriss_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  psum_collector_if.slave bus,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);
  localparam int W  = G_ARRAY_WIDTH;
  localparam int IW = $clog2(W);
  localparam int CW = $clog2(OUT_WIDTH);
  localparam int PW = 8;
  localparam int TW = $clog2(OUT_HEIGHT * OUT_WIDTH + 1);
  localparam int AW = G_OFMAP_ADDR_WIDTH;
  localparam logic [TW-1:0] TOTAL_WORDS = TW'(OUT_HEIGHT * OUT_WIDTH);

  collector_state_e r_state;
  logic [CW-1:0]    r_col_cnt  [W];
  logic [PW-1:0]    r_pass_cnt [W];
  logic [TW-1:0]    r_total;
  logic             r_wr_en;
  logic [AW-1:0]    r_wr_addr;
  logic [31:0]      r_wr_data;
  logic             r_err;

  logic             w_clear;
  logic             w_pop;
  logic [0:W-1]     w_req;
  logic [0:W-1]     w_gnt;
  logic [IW-1:0]    w_gnt_idx;
  logic [31:0]      w_row;
  logic             w_in_range;
  logic [31:0]      w_data_ext;

  assign w_clear = start_i && (r_state != RUN);
  assign w_req   = (r_state == RUN) ? ~bus.psum_empty_i : '0;
  assign w_pop   = |w_gnt;

  psum_rr_arbiter #(.N(W)) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (w_clear),
    .advance_i (w_pop),
    .req_i     (w_req),
    .gnt_o     (w_gnt)
  );

  always_comb begin
    w_gnt_idx = '0;
    for (int c = 0; c < W; c++) begin
      if (w_gnt[c]) w_gnt_idx = IW'(c);
    end
  end

  assign w_row      = 32'(w_gnt_idx) + 32'(r_pass_cnt[w_gnt_idx]) * 32'(ROW_STRIDE);
  assign w_in_range = w_row < 32'(OUT_HEIGHT);

  always_comb begin
    w_data_ext = {{(32-DATA_WIDTH){bus.psum_i[w_gnt_idx][DATA_WIDTH-1]}}, bus.psum_i[w_gnt_idx]};
`ifdef PSUM_COLLECTOR_RELU_EN
    if (w_data_ext[31]) w_data_ext = '0;
`endif
  end

  // Pass counter saturates so a runaway column can never wrap back into a legal row.
  for (genvar gi = 0; gi < W; gi++) begin : g_col
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_col_cnt[gi]  <= '0;
        r_pass_cnt[gi] <= '0;
      end else if (w_clear) begin
        r_col_cnt[gi]  <= '0;
        r_pass_cnt[gi] <= '0;
      end else if (w_gnt[gi]) begin
        if (r_col_cnt[gi] == CW'(OUT_WIDTH - 1)) begin
          r_col_cnt[gi] <= '0;
          if (r_pass_cnt[gi] != '1) r_pass_cnt[gi] <= r_pass_cnt[gi] + 1'b1;
        end else begin
          r_col_cnt[gi] <= r_col_cnt[gi] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_total   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_wr_en <= w_pop && w_in_range;
      if (w_pop && w_in_range) begin
        r_wr_addr <= AW'(w_row * 32'(OUT_WIDTH) + 32'(r_col_cnt[w_gnt_idx]));
        r_wr_data <= w_data_ext;
      end
      if (w_pop && !w_in_range) r_err <= 1'b1;
      if (r_wr_en) r_total <= r_total + 1'b1;

      // Finish only once the last accepted word has left the write register.
      unique case (r_state)
        IDLE, DONE: begin
          if (start_i) begin
            r_state <= RUN;
            r_total <= '0;
            r_err   <= 1'b0;
          end
        end
        RUN: begin
          if (r_total == TOTAL_WORDS && !r_wr_en) r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.psum_rd_en_o    = w_gnt;
  assign bus.ofmap_wr_en_o   = r_wr_en;
  assign bus.ofmap_wr_addr_o = r_wr_addr;
  assign bus.ofmap_wr_data_o = r_wr_data;
  assign busy_o              = (r_state == RUN);
  assign done_o              = (r_state == DONE);
  assign err_o               = r_err;
endmodule
